generations_cellular_automata_2d: RTL and testbench
===================================================

# generations_cellular_automata_2d

Parametrised successor to the binary life-like automaton in the `ca` library. The grid is Width×Height. Each cell holds one of `States` values: 0 dead, 1 alive, 2..States-1 dying/refractory, which gives "Generations"-family rules. The block adds a selectable toroidal or dead boundary, a run controller with a step budget and a generation counter, and automatic termination on extinction or a fixed point. It is the grid engine used by the genetic search loop to score rule/pattern candidates.

## Interface
- `Width`, 4, grid columns (≥3)
- `Height`, 4, grid rows (≥3)
- `StateBits`, 2, bits per cell
- `States`, 3, number of cell states (2..2^StateBits)
- `CountBits`, 16, width of step budget and generation counter
- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `ce`  in  1  clock enable; low freezes grid, FSM, counters and flags
- `load`  in  1  load `set` into grid (needs ce)
- `set`  in  Width*Height  load pattern: 1→alive(1), 0→dead(0); cell i = y*Width+x
- `survive`  in  9  bit n: an alive cell with n alive neighbours stays alive
- `rise`  in  9  bit n: a dead cell with n alive neighbours becomes alive
- `wrap`  in  1  1 toroidal edges, 0 off-grid cells count as dead
- `start`  in  1  begin run (needs ce, ignored while busy)
- `steps`  in  CountBits  generations to run; 0 = free run
- `stop`  in  1  abort run
- `state`  out  Width*Height*StateBits  cell i at [i*StateBits +: StateBits]
- `alive`  out  Width*Height  bit i = (cell i == 1)
- `busy`  out  1  run in progress
- `done`  out  1  one-cycle pulse when a run ends
- `generation`  out  CountBits  generations computed since last load/reset
- `extinct`  out  1  sticky: last run ended because the grid became all-zero
- `stable`  out  1  sticky: last run ended on a fixed point

## Operation
- FSM has two states, IDLE and RUN. Reset enters IDLE.
- Priority each ce edge: rst > load > stop > start > step.
- rst: all cells 0, generation 0, busy/done/extinct/stable 0, remaining counter 0.
- load (any state): grid←set, generation←0, extinct/stable←0, FSM→IDLE with no done pulse.
- start in IDLE: latch remaining←steps, clear extinct/stable, FSM→RUN. No generation is computed on the start edge.
- Step (RUN, ce=1): next grid is computed from the current grid and the current survive/rise/wrap.
  - Neighbour count n covers the 8 Moore neighbours whose state == 1 (range 0..8). Dying cells do not count.
  - Cell 0: becomes 1 if rise[n], else stays 0.
  - Cell 1: stays 1 if survive[n]; otherwise becomes 2, or 0 when States==2.
  - Cell k≥2: becomes k+1, or 0 when k+1 == States.
- generation increments by 1 per step and saturates at all-ones. In budget mode remaining decrements.
- A run terminates on the step edge where any of the following holds:
  - next grid all-zero: extinct←1. This takes precedence, so stable stays 0.
  - next == current: stable←1.
  - budget mode with remaining == 1.
- On termination, the grid takes the next value, FSM→IDLE, busy←0 and done←1 on the same edge.
- stop in RUN: no step that edge; FSM→IDLE, done pulse, flags unchanged. stop in IDLE is ignored.
- Free run (steps=0) ends only via stop, extinction or fixed point.

## Timing
- `state`, `alive` and all status outputs are registered; no combinational input→output paths.
- Latency: start sampled on edge 0 → busy=1 after edge 0. The first step is applied on the next ce edge.
- With ce held high and budget N (no early termination): busy is high N cycles, generation rises by N, and done pulses in the cycle after the Nth step edge.
- done is high exactly one cycle and clears on the next edge even if ce=0.
- ce=0 mid-run: grid, generation and remaining hold; busy stays 1.
- rst mid-run: grid clears on that edge; no done pulse.
- load and start on the same edge: load wins, start is dropped.

## Test plan
- Blinker, Conway (survive=9'b000001100, rise=9'b000001000), States=2, wrap=0, 4×4. Load row y=1, x=0..2; steps=2 → after step 1 alive = x=1, y=0..2; after step 2 the original row. done once, generation=2, stable=0, extinct=0.
- Block 2×2 at (1,1), steps=0 → terminates after first step; stable=1, generation=1, grid unchanged.
- Single cell (1,1), States=3, Conway, steps=0 → step 1 cell=2, step 2 all-zero; extinct=1, stable=0, generation=2.
- Wrap: row y=1 at x=3,0,1. With wrap=1, step 1 gives column x=0, y=0..2. With wrap=0 → extinct=1 after generation=1.
- Free-run blinker: ce low 3 cycles → generation and state frozen. stop → busy 0, done pulse, generation unchanged that edge. Then start+load same edge → load wins, busy stays 0.
- rst asserted mid-run → next cycle state=0, generation=0, busy=0, done=0.

Source files
------------

// File: rtl/generations_cellular_automata_2d.sv
// generations_cellular_automata_2d: Generations-family 2D automaton with run control, step budget and extinction/fixed-point stop
module generations_cellular_automata_2d #(
  parameter int Width = 4,
  parameter int Height = 4,
  parameter int StateBits = 2,
  parameter int States = 3,
  parameter int CountBits = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              ce,
  input  logic                              load,
  input  logic [Width*Height-1:0]           set,
  input  logic [8:0]                        survive,
  input  logic [8:0]                        rise,
  input  logic                              wrap,
  input  logic                              start,
  input  logic [CountBits-1:0]              steps,
  input  logic                              stop,
  output logic [Width*Height*StateBits-1:0] state,
  output logic [Width*Height-1:0]           alive,
  output logic                              busy,
  output logic                              done,
  output logic [CountBits-1:0]              generation,
  output logic                              extinct,
  output logic                              stable
);
  localparam int N = Width * Height;
  typedef enum logic {IDLE, RUN} fsm_t;
  fsm_t fsm, fsm_nx;
  logic [CountBits-1:0] remaining;
  logic [N*StateBits-1:0] nxt, ld;
  logic [N-1:0] live;
  logic zero, same, term;
  for (genvar y = 0; y < Height; y++) begin : g_row
    for (genvar x = 0; x < Width; x++) begin : g_col
      localparam int I = y * Width + x;
      logic [8:0] nb;
      logic [3:0] n;
      logic [StateBits-1:0] cur;
      for (genvar d = 0; d < 9; d++) begin : g_nb
        localparam int Xn = x + d % 3 - 1;
        localparam int Yn = y + d / 3 - 1;
        localparam bit Inside = Xn >= 0 && Xn < Width && Yn >= 0 && Yn < Height;
        localparam int Idx = ((Yn + Height) % Height) * Width + (Xn + Width) % Width;
        if (d == 4) begin : g_self
          assign nb[d] = 1'b0;
        end else begin : g_other
          assign nb[d] = (Inside || wrap) && live[Idx];
        end
      end
      assign cur = state[I*StateBits +: StateBits];
      assign live[I] = cur == StateBits'(1);
      assign n = 4'($countones(nb));
      assign ld[I*StateBits +: StateBits] = StateBits'(set[I]);
      // only state 1 counts as a neighbour; states >= 2 just age toward 0
      assign nxt[I*StateBits +: StateBits] = cur == '0 ? StateBits'(rise[n]) :
                                             live[I] ? (survive[n] ? cur : StateBits'(States == 2 ? 0 : 2)) :
                                             cur == StateBits'(States - 1) ? '0 : cur + 1'b1;
    end
  end
  assign zero = nxt == '0;
  assign same = nxt == state;
  // remaining is 0 in free run, so reaching 1 can only happen under a budget
  assign term = zero || same || remaining == CountBits'(1);
  assign alive = live;
  assign busy = fsm == RUN;
  always_comb begin
    fsm_nx = load ? IDLE : fsm == RUN ? ((stop || term) ? IDLE : RUN) : start ? RUN : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) fsm <= IDLE;
    else if (ce) fsm <= fsm_nx;
  end
  always_ff @(posedge clk) begin
    done <= 1'b0;
    if (rst) begin
      state <= '0;
      generation <= '0;
      remaining <= '0;
      extinct <= 1'b0;
      stable <= 1'b0;
    end else if (ce) begin
      if (load) begin
        state <= ld;
        generation <= '0;
        extinct <= 1'b0;
        stable <= 1'b0;
      end else if (fsm == RUN && stop) begin
        done <= 1'b1;
      end else if (fsm == IDLE && start) begin
        remaining <= steps;
        extinct <= 1'b0;
        stable <= 1'b0;
      end else if (fsm == RUN) begin
        state <= nxt;
        generation <= generation + CountBits'(generation != '1);
        remaining <= remaining - CountBits'(remaining != '0);
        extinct <= extinct | zero;
        stable <= stable | (same && !zero);
        done <= term;
      end
    end
  end
endmodule

// File: tb/tb_generations_cellular_automata_2d.sv
// tb_generations_cellular_automata_2d: two-state and three-state instances checked against a grid-level model
module tb_generations_cellular_automata_2d;
  typedef int grid_t [16];
  logic clk = 0, rst = 1, ce = 0, load = 0, wrap = 0, start = 0, stop = 0;
  logic [15:0] sset = 0, steps = 0;
  logic [8:0] survive = 9'b000001100, rise = 9'b000001000;
  logic [31:0] st2, st3;
  logic [15:0] al2, al3, gn2, gn3;
  logic bs2, bs3, dn2, dn3, ex2, ex3, sb2, sb3;
  grid_t mg [2];
  int mgen [2], mrem [2];
  bit mbud [2], mbusy [2], mdone [2], mext [2], mstab [2];
  int n_chk = 0, n_fail = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  generations_cellular_automata_2d #(.Width(4), .Height(4), .StateBits(2), .States(2), .CountBits(16)) d2 (
    .clk(clk), .rst(rst), .ce(ce), .load(load), .set(sset), .survive(survive), .rise(rise), .wrap(wrap),
    .start(start), .steps(steps), .stop(stop), .state(st2), .alive(al2), .busy(bs2), .done(dn2),
    .generation(gn2), .extinct(ex2), .stable(sb2));
  generations_cellular_automata_2d #(.Width(4), .Height(4), .StateBits(2), .States(3), .CountBits(16)) d3 (
    .clk(clk), .rst(rst), .ce(ce), .load(load), .set(sset), .survive(survive), .rise(rise), .wrap(wrap),
    .start(start), .steps(steps), .stop(stop), .state(st3), .alive(al3), .busy(bs3), .done(dn3),
    .generation(gn3), .extinct(ex3), .stable(sb3));

  function automatic grid_t step_grid(grid_t g, int s, logic [8:0] sv, logic [8:0] rs, logic w);
    grid_t o;
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 4; x++) begin
        int n = 0;
        int c = g[y*4+x];
        for (int dy = -1; dy <= 1; dy++)
          for (int dx = -1; dx <= 1; dx++) begin
            int xx = x + dx;
            int yy = y + dy;
            if (dx == 0 && dy == 0) continue;
            if (w) begin
              xx = (xx + 4) % 4;
              yy = (yy + 4) % 4;
            end else if (xx < 0 || xx > 3 || yy < 0 || yy > 3) continue;
            if (g[yy*4+xx] == 1) n++;
          end
        if (c == 0) o[y*4+x] = rs[n] ? 1 : 0;
        else if (c == 1) o[y*4+x] = sv[n] ? 1 : (s == 2 ? 0 : 2);
        else o[y*4+x] = (c + 1 == s) ? 0 : c + 1;
      end
    return o;
  endfunction

  function automatic logic [31:0] pk(grid_t g);
    logic [31:0] p = 0;
    for (int i = 0; i < 16; i++) p[2*i +: 2] = 2'(g[i]);
    return p;
  endfunction

  function automatic logic [15:0] pa(grid_t g);
    logic [15:0] p = 0;
    for (int i = 0; i < 16; i++) p[i] = g[i] == 1;
    return p;
  endfunction

  task automatic mupd(input int k);
    grid_t nx;
    bit z, same, last;
    int s = k == 0 ? 2 : 3;
    mdone[k] = 0;
    if (rst) begin
      for (int i = 0; i < 16; i++) mg[k][i] = 0;
      mgen[k] = 0; mrem[k] = 0; mbud[k] = 0; mbusy[k] = 0; mext[k] = 0; mstab[k] = 0;
    end else if (ce) begin
      if (load) begin
        for (int i = 0; i < 16; i++) mg[k][i] = int'(sset[i]);
        mgen[k] = 0; mext[k] = 0; mstab[k] = 0; mbusy[k] = 0;
      end else if (mbusy[k] && stop) begin
        mbusy[k] = 0; mdone[k] = 1;
      end else if (!mbusy[k] && start) begin
        mrem[k] = int'(steps); mbud[k] = steps != 0; mext[k] = 0; mstab[k] = 0; mbusy[k] = 1;
      end else if (mbusy[k]) begin
        nx = step_grid(mg[k], s, survive, rise, wrap);
        z = 1; same = 1;
        for (int i = 0; i < 16; i++) begin
          if (nx[i] != 0) z = 0;
          if (nx[i] != mg[k][i]) same = 0;
        end
        last = mbud[k] && mrem[k] == 1;
        if (mbud[k]) mrem[k]--;
        if (mgen[k] < 65535) mgen[k]++;
        if (z) mext[k] = 1;
        else if (same) mstab[k] = 1;
        if (z || same || last) begin mbusy[k] = 0; mdone[k] = 1; end
        mg[k] = nx;
      end
    end
  endtask

  always @(posedge clk) for (int k = 0; k < 2; k++) mupd(k);

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  task automatic cmpd(input int k, input logic [31:0] s, input logic [15:0] a, input logic b, input logic d,
                      input logic [15:0] g, input logic x, input logic sb);
    string p = k == 0 ? "s2" : "s3";
    chk({p, ".state"}, s, pk(mg[k]));
    chk({p, ".alive"}, a, pa(mg[k]));
    chk({p, ".busy"}, b, mbusy[k]);
    chk({p, ".done"}, d, mdone[k]);
    chk({p, ".generation"}, g, mgen[k]);
    chk({p, ".extinct"}, x, mext[k]);
    chk({p, ".stable"}, sb, mstab[k]);
  endtask

  always @(negedge clk) if (chk_en) begin
    cmpd(0, st2, al2, bs2, dn2, gn2, ex2, sb2);
    cmpd(1, st3, al3, bs3, dn3, gn3, ex3, sb3);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic go(input logic [15:0] p, input logic [15:0] n, input logic w);
    load = 1; sset = p; wrap = w;
    tick();
    load = 0; start = 1; steps = n;
    tick();
    start = 0;
  endtask

  initial begin
    ce = 1;
    tick(); tick();
    rst = 0; chk_en = 1;
    chk("reset_state", st2, 0); chk("reset_gen", gn2, 0); chk("reset_busy", bs2, 0);
    go(16'h0070, 2, 0);
    tick();
    chk("blinker_step1", al2, 16'h0222); chk("blinker3_step1", al3, 16'h0222);
    tick();
    chk("blinker_step2", al2, 16'h0070); chk("blinker_done", dn2, 1); chk("blinker_gen", gn2, 2);
    chk("blinker_stable", sb2, 0); chk("blinker_extinct", ex2, 0);
    tick();
    chk("blinker_done_clear", dn2, 0); chk("blinker_idle", bs2, 0);
    go(16'h0660, 0, 0);
    tick();
    chk("block_stable", sb2, 1); chk("block_gen", gn2, 1); chk("block_grid", al2, 16'h0660);
    chk("block_done", dn2, 1); chk("block3_stable", sb3, 1);
    go(16'h0020, 0, 0);
    tick();
    chk("single3_step1", st3, 32'h0000_0800); chk("single2_extinct", ex2, 1); chk("single2_gen", gn2, 1);
    tick();
    chk("single3_extinct", ex3, 1); chk("single3_stable", sb3, 0); chk("single3_gen", gn3, 2);
    chk("single3_grid", st3, 0);
    go(16'h00b0, 1, 1);
    tick();
    chk("wrap_column", al2, 16'h0111); chk("wrap_done", dn2, 1);
    go(16'h00b0, 0, 0);
    tick();
    chk("nowrap_extinct", ex2, 1); chk("nowrap_gen", gn2, 1);
    go(16'h0070, 0, 0);
    tick(); tick();
    ce = 0;
    repeat (3) begin
      tick();
      chk("freeze_gen", gn2, 2); chk("freeze_state", st2, 32'h0000_1500); chk("freeze_busy", bs2, 1);
    end
    ce = 1;
    tick();
    stop = 1;
    tick();
    stop = 0;
    chk("stop_busy", bs2, 0); chk("stop_done", dn2, 1); chk("stop_gen", gn2, 3);
    load = 1; start = 1; sset = 16'h0070;
    tick();
    load = 0; start = 0;
    chk("loadstart_busy", bs2, 0); chk("loadstart_gen", gn2, 0);
    tick();
    chk("loadstart_busy2", bs2, 0);
    go(16'h0070, 0, 0);
    tick();
    rst = 1;
    tick();
    rst = 0;
    chk("rst_state", st2, 0); chk("rst_gen", gn2, 0); chk("rst_busy", bs2, 0); chk("rst_done", dn2, 0);
    repeat (600) begin
      ce = $urandom_range(0, 99) < 85;
      load = $urandom_range(0, 19) == 0;
      if (load) begin
        sset = 16'($urandom);
        survive = 9'($urandom);
        rise = 9'($urandom) & 9'b111111110;
      end
      start = $urandom_range(0, 7) == 0;
      stop = !start && $urandom_range(0, 29) == 0;
      steps = 16'($urandom_range(0, 6));
      wrap = 1'($urandom);
      rst = $urandom_range(0, 149) == 0;
      tick();
    end
    rst = 0; load = 0; start = 0; stop = 0; ce = 1;
    tick(); tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
